// File: rtl/vga_timing_pkg.sv
// Purpose : shared timing constants and the coordinate type for the VGA
//           raster path. The DEF_* values describe standard 640x480@60
//           timing. H_TOTAL/V_TOTAL are the full line/frame lengths for
//           those values.
// Contents: DEF_* timing localparams, H_TOTAL, V_TOTAL, coord_t.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef logic [9:0] coord_t;

endpackage

// File: rtl/sync_delay_line.sv
// Purpose : fixed-length shift register. It delays sync strobes so that
//           they line up with downstream pipelined pixel data. With
//           DEPTH=0 the input goes straight to the output and no register
//           is built.
// Ports   : clk      - rising-edge clock
//           reset_n  - synchronous active-low reset. Every stage loads RESET_VAL.
//           din      - WIDTH-bit input
//           dout     - din delayed by DEPTH clocks
module sync_delay_line #(
   parameter int                 WIDTH     = 2,
   parameter int                 DEPTH     = 2,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = clk ^ reset_n;
         assign dout        = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing source. It scans DrawX/DrawY across the whole
//           frame and flags the visible region on blank (1 = visible).
//           It generates hs/vs and delays them by PIPE_DELAY clocks, so they
//           stay aligned with the registered RGB from the sprite mappers.
// Ports   : vga_clk     - pixel clock
//           reset_n     - synchronous active-low reset
//           DrawX/DrawY - current raster position
//           blank       - 1 inside the active area. Aligned with DrawX/DrawY.
//           hs/vs       - syncs at SYNC_POL when asserted, delayed PIPE_DELAY clocks
//           line_start  - high while DrawX==0
//           frame_start - high while DrawX==0 and DrawY==0
//           frame_count - frame starts since reset, 8-bit wrapping
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE   = DEF_H_ACTIVE,
   parameter int   H_FP       = DEF_H_FP,
   parameter int   H_SYNC     = DEF_H_SYNC,
   parameter int   H_BP       = DEF_H_BP,
   parameter int   V_ACTIVE   = DEF_V_ACTIVE,
   parameter int   V_FP       = DEF_V_FP,
   parameter int   V_SYNC     = DEF_V_SYNC,
   parameter int   V_BP       = DEF_V_BP,
   parameter logic SYNC_POL   = 1'b0,
   parameter int   PIPE_DELAY = 2
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output coord_t     DrawX,
   output coord_t     DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (LINE_LEN > 1024 || FRAME_LINES > 1024) begin : g_size_err
         $error("vga_timing_gen: line or frame total exceeds 1024");
      end
   endgenerate

   localparam coord_t H_LAST   = coord_t'(LINE_LEN - 1);
   localparam coord_t V_LAST   = coord_t'(FRAME_LINES - 1);
   localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
   localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
   localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

   coord_t     next_x;
   coord_t     next_y;
   logic       x_wrap;
   logic       frame_wrap;
   logic       hs_raw;
   logic       vs_raw;
   logic [1:0] sync_out;

   // The flags are decoded from next_x/next_y and registered with the
   // counters. This keeps blank and the pulses aligned with DrawX/DrawY.
   always_comb begin
      x_wrap     = (DrawX == H_LAST);
      frame_wrap = x_wrap && (DrawY == V_LAST);
      next_x     = x_wrap ? '0 : DrawX + 1'b1;
      next_y     = DrawY;
      if (x_wrap) next_y = (DrawY == V_LAST) ? '0 : DrawY + 1'b1;
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         // Parking on the last pixel makes the first enabled edge a frame wrap.
         // frame_count therefore reads 1 during the first frame.
         DrawX       <= H_LAST;
         DrawY       <= V_LAST;
         blank       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= 8'd0;
         hs_raw      <= ~SYNC_POL;
         vs_raw      <= ~SYNC_POL;
      end else begin
         DrawX       <= next_x;
         DrawY       <= next_y;
         blank       <= (next_x < H_VIS) && (next_y < V_VIS);
         line_start  <= (next_x == '0);
         frame_start <= (next_x == '0) && (next_y == '0);
         if (frame_wrap) frame_count <= frame_count + 8'd1;
         hs_raw      <= ((next_x >= HS_START) && (next_x < HS_END)) ? SYNC_POL : ~SYNC_POL;
         vs_raw      <= ((next_y >= VS_START) && (next_y < VS_END)) ? SYNC_POL : ~SYNC_POL;
      end
   end

   sync_delay_line #(
      .WIDTH     (2),
      .DEPTH     (PIPE_DELAY),
      .RESET_VAL ({~SYNC_POL, ~SYNC_POL})
   ) u_sync_delay (
      .clk     (vga_clk),
      .reset_n (reset_n),
      .din     ({hs_raw, vs_raw}),
      .dout    (sync_out)
   );

   assign hs = sync_out[1];
   assign vs = sync_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. It runs four builds: defaults, a medium frame,
// a tiny frame, and a PIPE_DELAY=0 build. All four share one clock and
// one reset. The expected outputs are derived from the elapsed clocks
// since reset release using plain div/mod arithmetic.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb, pd;
  } cfg_t;

  localparam cfg_t C_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam cfg_t C_MED = '{16, 2, 4, 2, 8, 2, 2, 3, 2};
  localparam cfg_t C_SML = '{8, 1, 1, 1, 4, 1, 1, 1, 2};
  localparam cfg_t C_P0  = '{640, 16, 96, 48, 4, 1, 1, 1, 0};

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int t = -1;
  logic t_valid = 1'b0;

  // Elapsed-clock tracker. -1 means the previous edge sampled reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      t <= -1;
      t_valid <= 1'b1;
    end else begin
      t <= t + 1;
    end
  end

  coord_t d_x, d_y, m_x, m_y, s_x, s_y, p_x, p_y;
  logic d_bl, d_hs, d_vs, d_ls, d_fs;
  logic m_bl, m_hs, m_vs, m_ls, m_fs;
  logic s_bl, s_hs, s_vs, s_ls, s_fs;
  logic p_bl, p_hs, p_vs, p_ls, p_fs;
  logic [7:0] d_fc, m_fc, s_fc, p_fc;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_bl),
    .hs(d_hs), .vs(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
                   .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_med (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(m_x), .DrawY(m_y), .blank(m_bl),
    .hs(m_hs), .vs(m_vs), .line_start(m_ls), .frame_start(m_fs), .frame_count(m_fc));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_sml (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_bl),
    .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));

  vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DELAY(0)) u_p0 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(p_x), .DrawY(p_y), .blank(p_bl),
    .hs(p_hs), .vs(p_vs), .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc));

  // Reference model. It returns the expected outputs packed as
  // {x, y, blank, hs, vs, line_start, frame_start, frame_count}.
  function automatic logic [32:0] model(input cfg_t c, input int tt);
    int ht, vt, x, y, fc, ts, xs, ys;
    logic bl, hs, vs, ls, fs;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    if (tt < 0) begin
      x = ht - 1; y = vt - 1; bl = 0; ls = 0; fs = 0; fc = 0; hs = 1; vs = 1;
    end else begin
      x  = tt % ht;
      y  = (tt / ht) % vt;
      bl = (x < c.ha) && (y < c.va);
      ls = (x == 0);
      fs = (x == 0) && (y == 0);
      fc = (tt / (ht * vt) + 1) % 256;
      ts = tt - c.pd;
      if (ts < 0) begin
        hs = 1; vs = 1;
      end else begin
        xs = ts % ht;
        ys = (ts / ht) % vt;
        hs = !((xs >= c.ha + c.hf) && (xs < c.ha + c.hf + c.hsw));
        vs = !((ys >= c.va + c.vf) && (ys < c.va + c.vf + c.vsw));
      end
    end
    return {10'(x), 10'(y), bl, hs, vs, ls, fs, 8'(fc)};
  endfunction

  // scoreboard
  task automatic chk(input string nm, input cfg_t c, input logic [32:0] act);
    logic [32:0] exp;
    exp = model(c, t);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h want=%h {x,y,blank,hs,vs,ls,fs,fc}", nm, t, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0d want=%0d", nm, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (t_valid) begin
      chk("def", C_DEF, {d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc});
      chk("med", C_MED, {m_x, m_y, m_bl, m_hs, m_vs, m_ls, m_fs, m_fc});
      chk("sml", C_SML, {s_x, s_y, s_bl, s_hs, s_vs, s_ls, s_fs, s_fc});
      chk("p0",  C_P0,  {p_x, p_y, p_bl, p_hs, p_vs, p_ls, p_fs, p_fc});
      case (t)
        -1: begin
          lit("rst_x", 32'(d_x), 799);   lit("rst_y", 32'(d_y), 524);
          lit("rst_blank", 32'(d_bl), 0); lit("rst_hs", 32'(d_hs), 1);
          lit("rst_vs", 32'(d_vs), 1);   lit("rst_fc", 32'(d_fc), 0);
          lit("rst_fs", 32'(d_fs), 0);   lit("rst_ls", 32'(d_ls), 0);
        end
        0: begin
          lit("first_x", 32'(d_x), 0);    lit("first_y", 32'(d_y), 0);
          lit("first_blank", 32'(d_bl), 1); lit("first_ls", 32'(d_ls), 1);
          lit("first_fs", 32'(d_fs), 1);  lit("first_fc", 32'(d_fc), 1);
        end
        77:  begin lit("sml_fs_77", 32'(s_fs), 1); lit("sml_fc_77", 32'(s_fc), 2); end
        192: lit("med_blank_y8", 32'(m_bl), 0);
        241: lit("med_vs_241", 32'(m_vs), 1);
        242: begin lit("med_vs_242", 32'(m_vs), 0); lit("med_y_242", 32'(m_y), 10);
                   lit("med_x_242", 32'(m_x), 2); end
        289: lit("med_vs_289", 32'(m_vs), 0);
        290: lit("med_vs_290", 32'(m_vs), 1);
        359: lit("med_fs_359", 32'(m_fs), 0);
        360: begin lit("med_fs_360", 32'(m_fs), 1); lit("med_fc_360", 32'(m_fc), 2); end
        639: lit("def_blank_639", 32'(d_bl), 1);
        640: begin lit("def_blank_640", 32'(d_bl), 0); lit("def_x_640", 32'(d_x), 640); end
        655: lit("p0_hs_655", 32'(p_hs), 1);
        656: lit("p0_hs_656", 32'(p_hs), 0);
        657: lit("def_hs_657", 32'(d_hs), 1);
        658: lit("def_hs_658", 32'(d_hs), 0);
        751: lit("p0_hs_751", 32'(p_hs), 0);
        752: lit("p0_hs_752", 32'(p_hs), 1);
        753: lit("def_hs_753", 32'(d_hs), 0);
        754: lit("def_hs_754", 32'(d_hs), 1);
        800: begin lit("def_ls_800", 32'(d_ls), 1); lit("def_y_800", 32'(d_y), 1);
                   lit("def_fs_800", 32'(d_fs), 0); end
        1500: lit("def_hs_mid_pulse", 32'(d_hs), 0);
        3999: lit("p0_vs_3999", 32'(p_vs), 1);
        4000: lit("p0_vs_4000", 32'(p_vs), 0);
        4799: lit("p0_vs_4799", 32'(p_vs), 0);
        4800: lit("p0_vs_4800", 32'(p_vs), 1);
        77 * 254: lit("sml_fc_255", 32'(s_fc), 255);
        77 * 255: begin lit("sml_fc_wrap", 32'(s_fc), 0); lit("sml_fs_wrap", 32'(s_fs), 1); end
        default: ;
      endcase
    end
  end

  // driver
  initial begin
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    // Run until the default build sits inside the line-1 hsync pulse
    // (DrawX=700, DrawY=1), then drop reset for exactly one clock.
    for (int i = 0; i < 5000 && t != 1500; i++) @(negedge clk);
    n_checks++;
    if (t != 1500) begin
      n_err++;
      $display("FAIL reach_mid_pulse t=%0d want=1500", t);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    // Long enough for the tiny frame's counter to wrap 255 -> 0.
    repeat (77 * 256 + 200) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
